adder_pipe_nbit: RTL and testbench
==================================

ADDER_PIPE_NBIT -- requirements
Module: adder_pipe_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; NUM_STAGES = WIDTH/CHUNK.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrap-around result, 1 = saturating result.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports, in order: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand set offered this cycle.
REQ-008 in_ready  out  1  pipeline accepts operand set this cycle.
REQ-009 a  in  WIDTH  operand A.
REQ-010 b  in  WIDTH  operand B.
REQ-011 carry_in  in  1  carry into bit 0.
REQ-012 signed_mode  in  1  1 = two's-complement overflow/saturation rules for this transaction.
REQ-013 out_valid  out  1  sum/overflow valid.
REQ-014 out_ready  in  1  consumer accepts result this cycle.
REQ-015 sum  out  WIDTH  result.
REQ-016 overflow  out  1  overflow flag for the result.

Function
REQ-017 Input handshake: transfer when in_valid && in_ready at a rising clk edge; a, b, carry_in, signed_mode sampled together.
REQ-018 Output handshake: transfer when out_valid && out_ready; sum/overflow/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-019 Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational); no stage register changes when advance=0.
REQ-020 Stage k (0..NUM_STAGES-1) SHALL add chunk k of a and b plus carry from stage k-1 (stage 0 uses carry_in); unconsumed upper operand chunks and finished lower sum chunks are carried forward in stage registers.
REQ-021 Latency: with out_ready held 1, a result SHALL appear on out_valid exactly NUM_STAGES cycles after its input transfer; throughput one transaction per cycle.
REQ-022 Results SHALL leave in input order; no loss or duplication; bubbles propagate (no collapse).
REQ-023 Raw result R = a + b + carry_in, WIDTH+1 bits; unsigned carry C = R[WIDTH].
REQ-024 signed_mode=0: overflow = C.
REQ-025 signed_mode=1: overflow = (a[MSB]==b[MSB]) && (R[MSB]!=a[MSB]).
REQ-026 SAT=0: sum = R[WIDTH-1:0] (wrap-around).
REQ-027 SAT=1, overflow=1: unsigned -> all ones; signed -> 0x7F..F if a[MSB]=0, else 0x80..0; overflow still reported 1.
REQ-028 When out_valid=0, sum and overflow SHALL hold their last value (0 after reset).

Reset
REQ-029 rst=1 at a rising edge SHALL clear all stage valids, out_valid=0, sum=0, overflow=0, discarding all in-flight transactions; no result emitted for them.
REQ-030 in_ready SHALL be 1 in the cycle after reset (pipeline empty); rst dominates in_valid in the same cycle (input not captured).

Verification (WIDTH=16, CHUNK=4, SAT=0 unless stated)
REQ-031 Reset: rst 1 cycle -> out_valid=0, sum=0x0000, overflow=0, in_ready=1.
REQ-032 a=0xFFFF, b=0x0001, cin=0, signed_mode=0, out_ready=1 -> exactly 4 cycles later out_valid=1, sum=0x0000, overflow=1.
REQ-033 a=0x7FFF, b=0x0001, signed_mode=1 -> sum=0x8000, overflow=1; with SAT=1 -> sum=0x7FFF, overflow=1; a=0x8000,b=0xFFFF,SAT=1 -> sum=0x8000, overflow=1.
REQ-034 Eight back-to-back inputs (i, 0x1000*i, cin=1), out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs held, all 8 sums 0x1001*i+1 delivered in order.
REQ-035 rst asserted with 2 transactions in flight -> next cycle out_valid=0, neither result ever appears.
REQ-036 WIDTH=4, CHUNK=2: all 512 {carry_in,b,a} combinations, both signed_mode values -> sum/overflow match REQ-023..REQ-026 for every case.

Source files
------------

// File: rtl/adder_pipe_nbit.sv
// Chunked ripple-carry adder: one CHUNK-bit slice per pipeline stage, with a
// global valid/ready stall, unsigned/signed overflow detection and optional saturation.
module adder_pipe_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    localparam int NUM_STAGES = WIDTH / CHUNK;

    function automatic logic ovf_of(input logic [WIDTH:0] r, input logic a_msb,
                                    input logic b_msb, input logic sm);
        if (sm)
            return (a_msb == b_msb) && (r[WIDTH-1] != a_msb);
        return r[WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw_sum,
                                                  input logic ovf, input logic a_msb,
                                                  input logic sm);
        logic [WIDTH-1:0] res;
        res = raw_sum;
        if (SAT != 0 && ovf) begin
            if (!sm)
                res = '1;
            else if (a_msb)
                res = {1'b1, {(WIDTH-1){1'b0}}};
            else
                res = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    logic                  advance;

    // Stage k holds a transaction whose chunk k is the next one to be added.
    logic [NUM_STAGES-1:0] vld_q, vld_d;
    logic [NUM_STAGES-1:0] carry_q, carry_d;
    logic [NUM_STAGES-1:0] sm_q, sm_d;
    logic [WIDTH-1:0]      a_q    [NUM_STAGES];
    logic [WIDTH-1:0]      a_d    [NUM_STAGES];
    logic [WIDTH-1:0]      b_q    [NUM_STAGES];
    logic [WIDTH-1:0]      b_d    [NUM_STAGES];
    logic [WIDTH-1:0]      part_q [NUM_STAGES];
    logic [WIDTH-1:0]      part_d [NUM_STAGES];
    logic [CHUNK:0]        chunk_sum [NUM_STAGES];

    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic                  overflow_q, overflow_d;

    logic [WIDTH-1:0]      final_lo;
    logic [WIDTH:0]        final_raw;
    logic                  final_ovf;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_chunk
        assign chunk_sum[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                            + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                            + (CHUNK+1)'(carry_q[k]);
    end

    always_comb begin
        final_lo = part_q[NUM_STAGES-1];
        final_lo[(NUM_STAGES-1)*CHUNK +: CHUNK] = chunk_sum[NUM_STAGES-1][CHUNK-1:0];
        final_raw = {chunk_sum[NUM_STAGES-1][CHUNK], final_lo};
        final_ovf = ovf_of(final_raw, a_q[NUM_STAGES-1][WIDTH-1],
                           b_q[NUM_STAGES-1][WIDTH-1], sm_q[NUM_STAGES-1]);
    end

    always_comb begin
        vld_d       = vld_q;
        carry_d     = carry_q;
        sm_d        = sm_q;
        a_d         = a_q;
        b_d         = b_q;
        part_d      = part_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        overflow_d  = overflow_q;

        if (advance) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                a_d[0]     = a;
                b_d[0]     = b;
                part_d[0]  = '0;
                carry_d[0] = carry_in;
                sm_d[0]    = signed_mode;
            end

            for (int k = 1; k < NUM_STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    a_d[k]     = a_q[k-1];
                    b_d[k]     = b_q[k-1];
                    part_d[k]  = part_q[k-1];
                    part_d[k][(k-1)*CHUNK +: CHUNK] = chunk_sum[k-1][CHUNK-1:0];
                    carry_d[k] = chunk_sum[k-1][CHUNK];
                    sm_d[k]    = sm_q[k-1];
                end
            end

            // Result registers only load on a real transaction so they hold through bubbles.
            out_valid_d = vld_q[NUM_STAGES-1];
            if (vld_q[NUM_STAGES-1]) begin
                overflow_d = final_ovf;
                sum_d      = saturate(final_lo, final_ovf, a_q[NUM_STAGES-1][WIDTH-1],
                                      sm_q[NUM_STAGES-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        carry_q <= carry_d;
        sm_q    <= sm_d;
        a_q     <= a_d;
        b_q     <= b_d;
        part_q  <= part_d;
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit: 16-bit wrap and saturating instances sharing
// stimulus, plus a 4-bit/2-bit-chunk instance swept over every operand combination.
module tb_adder_pipe_nbit;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv16, ordy16, cin16, sm16;
    logic [15:0] a16, b16;
    logic        ir16, ov16, of16;
    logic [15:0] sum16;
    logic        ir16s, ov16s, of16s;
    logic [15:0] sum16s;

    logic        iv4, ordy4, cin4, sm4;
    logic [3:0]  a4, b4;
    logic        ir4, ov4, of4;
    logic [3:0]  sum4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    adder_pipe_nbit #(.WIDTH(16), .CHUNK(4), .SAT(0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .carry_in(cin16), .signed_mode(sm16), .out_valid(ov16), .out_ready(ordy16),
        .sum(sum16), .overflow(of16)
    );

    adder_pipe_nbit #(.WIDTH(16), .CHUNK(4), .SAT(1)) dut16s (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16s), .a(a16), .b(b16),
        .carry_in(cin16), .signed_mode(sm16), .out_valid(ov16s), .out_ready(ordy16),
        .sum(sum16s), .overflow(of16s)
    );

    adder_pipe_nbit #(.WIDTH(4), .CHUNK(2), .SAT(0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .carry_in(cin4), .signed_mode(sm4), .out_valid(ov4), .out_ready(ordy4),
        .sum(sum4), .overflow(of4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; sm16 = 1'b0;
        iv4 = 1'b1; a4 = 4'h3; b4 = 4'h1;
        tick();
        tick();
        rst = 1'b0; iv16 = 1'b0; iv4 = 1'b0;
        #1;
        tests_run++;
        if (ov16 !== 1'b0 || sum16 !== 16'h0000 || of16 !== 1'b0 || ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset16: ov=%b sum=%h of=%b ir=%b required 0 0000 0 1", ov16, sum16, of16, ir16);
        end
        tests_run++;
        if (ov16s !== 1'b0 || sum16s !== 16'h0000 || of16s !== 1'b0 || ir16s !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset16s: ov=%b sum=%h of=%b ir=%b required 0 0000 0 1", ov16s, sum16s, of16s, ir16s);
        end
        tests_run++;
        if (ov4 !== 1'b0 || sum4 !== 4'h0 || of4 !== 1'b0 || ir4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset4: ov=%b sum=%h of=%b ir=%b required 0 0 0 1", ov4, sum4, of4, ir4);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (ov16 !== 1'b0 || ov4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_capture: ov16=%b ov4=%b required 0 0", ov16, ov4);
            end
        end
    endtask

    task automatic test_unsigned_carry();
        ordy16 = 1'b1;
        iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sm16 = 1'b0;
        #1;
        tests_run++;
        if (ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry_in_ready: got %b required 1", ir16);
        end
        tick();
        iv16 = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            tests_run++;
            if (ov16 !== 1'b0) begin
                tests_failed++;
                $display("FAIL carry_latency_early: cycle %0d out_valid=%b required 0", i, ov16);
            end
        end
        tick();
        tests_run++;
        if (ov16 !== 1'b1 || sum16 !== 16'h0000 || of16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL carry_result: ov=%b sum=%h of=%b required 1 0000 1", ov16, sum16, of16);
        end
        tick();
    endtask

    task automatic test_signed_sat();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vs [4];
        logic [15:0] e0_sum [4];
        logic [15:0] e1_sum [4];
        logic        e_ovf  [4];
        int sent = 0;
        int got  = 0;
        va     = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000};
        vb     = '{16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
        vs     = '{1'b1, 1'b1, 1'b1, 1'b0};
        e0_sum = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
        e1_sum = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        e_ovf  = '{1'b1, 1'b1, 1'b0, 1'b1};
        ordy16 = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            iv16 = (sent < 4);
            if (sent < 4) begin
                a16 = va[sent]; b16 = vb[sent]; sm16 = vs[sent]; cin16 = 1'b0;
            end
            #1;
            if (ov16 === 1'b1) begin
                tests_run++;
                if (sum16 !== e0_sum[got] || of16 !== e_ovf[got]) begin
                    tests_failed++;
                    $display("FAIL signed_wrap[%0d]: sum=%h of=%b required %h %b", got, sum16, of16, e0_sum[got], e_ovf[got]);
                end
                tests_run++;
                if (ov16s !== 1'b1 || sum16s !== e1_sum[got] || of16s !== e_ovf[got]) begin
                    tests_failed++;
                    $display("FAIL signed_sat[%0d]: ov=%b sum=%h of=%b required 1 %h %b", got, ov16s, sum16s, of16s, e1_sum[got], e_ovf[got]);
                end
                got++;
            end
            if (iv16 && ir16) sent++;
            tick();
        end
        iv16 = 1'b0;
        tests_run++;
        if (got != 4) begin
            tests_failed++;
            $display("FAIL signed_count: got %0d results required 4", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_sum [8];
        logic [15:0] held_sum;
        logic        held_valid;
        logic        stall;
        int sent = 0;
        int got  = 0;
        held_valid = 1'b0;
        held_sum   = '0;
        for (int i = 0; i < 8; i++) exp_sum[i] = 16'(32'h1001 * i + 1);
        for (int c = 0; c < 60 && got < 8; c++) begin
            stall  = (c >= 6 && c < 9);
            ordy16 = !stall;
            iv16   = (sent < 8);
            a16    = 16'(sent);
            b16    = 16'(32'h1000 * sent);
            cin16  = 1'b1;
            sm16   = 1'b0;
            #1;
            if (held_valid) begin
                tests_run++;
                if (ov16 !== 1'b1 || sum16 !== held_sum) begin
                    tests_failed++;
                    $display("FAIL b2b_hold: ov=%b sum=%h required 1 %h", ov16, sum16, held_sum);
                end
            end
            if (stall && ov16 === 1'b1) begin
                tests_run++;
                if (ir16 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_stall_ready: in_ready=%b required 0", ir16);
                end
            end
            if (ov16 === 1'b1 && ordy16) begin
                tests_run++;
                if (sum16 !== exp_sum[got] || of16 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_sum[%0d]: sum=%h of=%b required %h 0", got, sum16, of16, exp_sum[got]);
                end
                got++;
            end
            held_valid = (ov16 === 1'b1) && !ordy16;
            held_sum   = sum16;
            if (iv16 && ir16) sent++;
            tick();
        end
        iv16 = 1'b0; ordy16 = 1'b1;
        tests_run++;
        if (got != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results required 8", got);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (ov16 !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_duplicate: out_valid=%b required 0", ov16);
            end
        end
    endtask

    task automatic test_flush();
        ordy16 = 1'b1;
        iv16 = 1'b1; a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; sm16 = 1'b0;
        tick();
        a16 = 16'h0002;
        tick();
        rst = 1'b1; a16 = 16'h0003;
        tick();
        rst = 1'b0; iv16 = 1'b0;
        tests_run++;
        if (ov16 !== 1'b0 || sum16 !== 16'h0000 || of16 !== 1'b0 || ir16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_state: ov=%b sum=%h of=%b ir=%b required 0 0000 0 1", ov16, sum16, of16, ir16);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (ov16 !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_leak: cycle %0d out_valid=%b sum=%h required 0", i, ov16, sum16);
            end
        end
    endtask

    task automatic test_exhaustive_4bit();
        logic [9:0] v;
        logic [3:0] ea, eb;
        logic       ec, es, eo;
        logic [4:0] r;
        int sent = 0;
        int got  = 0;
        ordy4 = 1'b1;
        for (int c = 0; c < 1200 && got < 1024; c++) begin
            v   = 10'(sent);
            iv4 = (sent < 1024);
            a4  = v[3:0]; b4 = v[7:4]; cin4 = v[8]; sm4 = v[9];
            #1;
            if (ov4 === 1'b1) begin
                v  = 10'(got);
                ea = v[3:0]; eb = v[7:4]; ec = v[8]; es = v[9];
                r  = {1'b0, ea} + {1'b0, eb} + {4'b0000, ec};
                eo = es ? ((ea[3] == eb[3]) && (r[3] != ea[3])) : r[4];
                tests_run++;
                if (sum4 !== r[3:0] || of4 !== eo) begin
                    tests_failed++;
                    $display("FAIL exh4[%0d]: a=%h b=%h cin=%b sm=%b sum=%h of=%b required %h %b", got, ea, eb, ec, es, sum4, of4, r[3:0], eo);
                end
                got++;
            end
            if (iv4 && ir4) sent++;
            tick();
        end
        iv4 = 1'b0;
        tests_run++;
        if (got != 1024) begin
            tests_failed++;
            $display("FAIL exh4_count: got %0d results required 1024", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        iv16 = 1'b0; ordy16 = 1'b1; cin16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        iv4 = 1'b0; ordy4 = 1'b1; cin4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_unsigned_carry();
        test_signed_sat();
        test_back_to_back();
        test_flush();
        test_exhaustive_4bit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
